alu_instr_sequencer: RTL and testbench

Parametrised control-step sequencer for the bus-based CPU datapath. It generates, one control step per clock, the PCout/MARin/IncPC/Zin/Zlowout/PCin/Read/MDRin/MDRout/IRin/Yin/R*in/R*out signals for fetching and executing a register-register ALU instruction.
It generalises the fixed six-step T0..T5 flow in three ways:
- register file size and opcode width are parameters;
- memory wait states are handled through a ready handshake;
- one-operand ops take a shortened path, and multiply/divide (optional) take an extended path.
It sits between the instruction register and the Datapath control inputs.

---
 rtl/alu_instr_sequencer_pkg.sv | 57 +++++
 rtl/alu_instr_sequencer_if.sv | 47 ++++
 rtl/alu_instr_sequencer_reg_onehot_dec.sv | 20 ++
 rtl/alu_instr_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_alu_instr_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_instr_sequencer_pkg.sv
// Shared control definitions for the ALU instruction sequencer: step states,
// opcode values, default field widths and IR field positions.
package cpu_ctrl_pkg;

   localparam int OPCODE_WIDTH = 5;

   localparam int FIELD_OPC = 0;
   localparam int FIELD_RA  = 1;
   localparam int FIELD_RB  = 2;
   localparam int FIELD_RC  = 3;

   localparam int OP_ADD  = 3;
   localparam int OP_SUB  = 4;
   localparam int OP_AND  = 5;
   localparam int OP_OR   = 6;
   localparam int OP_ROR  = 7;
   localparam int OP_ROL  = 8;
   localparam int OP_SHR  = 9;
   localparam int OP_SHRA = 10;
   localparam int OP_SHL  = 11;
   localparam int OP_MUL  = 15;
   localparam int OP_DIV  = 16;
   localparam int OP_NEG  = 17;
   localparam int OP_NOT  = 18;

   typedef enum logic [2:0] {
      IDLE,
      T0,
      T1,
      T2,
      T3,
      T4,
      T5,
      T6
   } state_t;

   // Fields are packed from the IR MSB downward: opcode, Ra, Rb, Rc.
   function automatic int field_msb(input int data_w, input int opc_w,
                                    input int sel_w, input int field);
      if (field == FIELD_OPC)
         return data_w - 1;
      return data_w - 1 - opc_w - (field - 1) * sel_w;
   endfunction

   function automatic logic is_alu_binary(input int op);
      return (op >= OP_ADD) && (op <= OP_SHL);
   endfunction

   function automatic logic is_unary(input int op);
      return (op == OP_NEG) || (op == OP_NOT);
   endfunction

   function automatic logic is_muldiv(input int op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Control bundle between the instruction sequencer (master) and the bus-based
// datapath (slave).
interface alu_instr_sequencer_if #(
   parameter int DATA_WIDTH   = 32,
   parameter int NUM_REGS     = 16,
   parameter int OPCODE_WIDTH = 5
);
   logic                    run;
   logic                    mem_ready;
   logic [DATA_WIDTH-1:0]   ir;

   logic                    PCout;
   logic                    Zlowout;
   logic                    Zhighout;
   logic                    MDRout;
   logic                    MARin;
   logic                    Zin;
   logic                    PCin;
   logic                    MDRin;
   logic                    IRin;
   logic                    Yin;
   logic                    LOin;
   logic                    HIin;
   logic                    IncPC;
   logic                    Read;
   logic [NUM_REGS-1:0]     R_in;
   logic [NUM_REGS-1:0]     R_out;
   logic [OPCODE_WIDTH-1:0] alu_op;
   logic                    busy;
   logic                    done;
   logic                    illegal_op;

   modport master (
      input  run, mem_ready, ir,
      output PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin,
             Yin, LOin, HIin, IncPC, Read, R_in, R_out, alu_op, busy, done,
             illegal_op
   );

   modport slave (
      output run, mem_ready, ir,
      input  PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin,
             Yin, LOin, HIin, IncPC, Read, R_in, R_out, alu_op, busy, done,
             illegal_op
   );

endinterface

// File: rtl/alu_instr_sequencer_reg_onehot_dec.sv
// Register index to one-hot enable decoder; indices at or above NUM_REGS
// decode to all zeros.
module reg_onehot_dec #(
   parameter int REG_SEL_WIDTH = 4,
   parameter int NUM_REGS      = 16
) (
   input  logic [REG_SEL_WIDTH-1:0] idx,
   input  logic                     en,
   output logic [NUM_REGS-1:0]      onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (en && (int'(idx) == i))
            onehot[i] = 1'b1;
      end
   end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Control-step sequencer for fetch/execute of register-register ALU instructions.
// Define MULDIV_EN to enable the extended mul/div path (T3-T4-T5-T6).
module alu_instr_sequencer #(
   parameter int DATA_WIDTH    = 32,
   parameter int NUM_REGS      = 16,
   parameter int REG_SEL_WIDTH = 4,
   parameter int OPCODE_WIDTH  = cpu_ctrl_pkg::OPCODE_WIDTH
) (
   input logic                  Clock,
   input logic                  Clear_n,
   alu_instr_sequencer_if.master bus
);
   import cpu_ctrl_pkg::*;

   localparam int OPC_MSB = field_msb(DATA_WIDTH, OPCODE_WIDTH, REG_SEL_WIDTH, FIELD_OPC);
   localparam int RA_MSB  = field_msb(DATA_WIDTH, OPCODE_WIDTH, REG_SEL_WIDTH, FIELD_RA);
   localparam int RB_MSB  = field_msb(DATA_WIDTH, OPCODE_WIDTH, REG_SEL_WIDTH, FIELD_RB);
   localparam int RC_MSB  = field_msb(DATA_WIDTH, OPCODE_WIDTH, REG_SEL_WIDTH, FIELD_RC);

   state_t                   state;
   state_t                   state_next;
   logic                     t1_seen;

   logic [OPCODE_WIDTH-1:0]  opcode;
   logic [REG_SEL_WIDTH-1:0] ra;
   logic [REG_SEL_WIDTH-1:0] rb;
   logic [REG_SEL_WIDTH-1:0] rc;
   logic                     op_alu;
   logic                     op_unary;
   logic                     dec_binary;
   logic                     dec_unary;
   logic                     dec_muldiv;

   logic [REG_SEL_WIDTH-1:0] rout_idx;
   logic                     rout_en;
   logic                     rin_en;

   function automatic logic idx_ok(input logic [REG_SEL_WIDTH-1:0] idx);
      return int'(idx) < NUM_REGS;
   endfunction

   assign opcode = bus.ir[OPC_MSB -: OPCODE_WIDTH];
   assign ra     = bus.ir[RA_MSB -: REG_SEL_WIDTH];
   assign rb     = bus.ir[RB_MSB -: REG_SEL_WIDTH];
   assign rc     = bus.ir[RC_MSB -: REG_SEL_WIDTH];

   // Register fields that would be used but cannot name a register make the op illegal.
   always_comb begin
      op_alu   = is_alu_binary(int'(opcode));
      op_unary = is_unary(int'(opcode));
`ifdef MULDIV_EN
      dec_muldiv = is_muldiv(int'(opcode)) && idx_ok(rb) && idx_ok(rc);
`else
      dec_muldiv = 1'b0;
`endif
      dec_binary = (op_alu && idx_ok(ra) && idx_ok(rb) && idx_ok(rc)) || dec_muldiv;
      dec_unary  = op_unary && idx_ok(ra) && idx_ok(rb);
   end

   always_ff @(posedge Clock or negedge Clear_n) begin
      if (!Clear_n) begin
         state   <= IDLE;
         t1_seen <= 1'b0;
      end else begin
         state   <= state_next;
         t1_seen <= (state == T1);
      end
   end

   always_comb begin
      state_next     = state;
      bus.PCout      = 1'b0;
      bus.Zlowout    = 1'b0;
      bus.Zhighout   = 1'b0;
      bus.MDRout     = 1'b0;
      bus.MARin      = 1'b0;
      bus.Zin        = 1'b0;
      bus.PCin       = 1'b0;
      bus.MDRin      = 1'b0;
      bus.IRin       = 1'b0;
      bus.Yin        = 1'b0;
      bus.LOin       = 1'b0;
      bus.HIin       = 1'b0;
      bus.IncPC      = 1'b0;
      bus.Read       = 1'b0;
      bus.alu_op     = '0;
      bus.busy       = (state != IDLE);
      bus.done       = 1'b0;
      bus.illegal_op = 1'b0;
      rout_idx       = rb;
      rout_en        = 1'b0;
      rin_en         = 1'b0;

      unique case (state)
         IDLE: begin
            if (bus.run)
               state_next = T0;
         end
         T0: begin
            bus.PCout  = 1'b1;
            bus.MARin  = 1'b1;
            bus.IncPC  = 1'b1;
            bus.Zin    = 1'b1;
            state_next = T1;
         end
         // Wait states repeat T1; PC is loaded only on its first cycle.
         T1: begin
            bus.Zlowout = 1'b1;
            bus.Read    = 1'b1;
            bus.MDRin   = 1'b1;
            bus.PCin    = !t1_seen;
            if (bus.mem_ready)
               state_next = T2;
         end
         T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
            state_next = T3;
         end
         T3: begin
            if (dec_binary) begin
               rout_en    = 1'b1;
               bus.Yin    = 1'b1;
               state_next = T4;
            end else if (dec_unary) begin
               rout_en    = 1'b1;
               bus.alu_op = opcode;
               bus.Zin    = 1'b1;
               state_next = T5;
            end else begin
               bus.illegal_op = 1'b1;
               state_next     = IDLE;
            end
         end
         T4: begin
            rout_idx   = rc;
            rout_en    = 1'b1;
            bus.alu_op = opcode;
            bus.Zin    = 1'b1;
            state_next = T5;
         end
         T5: begin
            bus.Zlowout = 1'b1;
            if (dec_muldiv) begin
`ifdef MULDIV_EN
               bus.LOin   = 1'b1;
               state_next = T6;
`endif
            end else begin
               rin_en     = 1'b1;
               bus.done   = 1'b1;
               state_next = IDLE;
            end
         end
         T6: begin
`ifdef MULDIV_EN
            bus.Zhighout = 1'b1;
            bus.HIin     = 1'b1;
            bus.done     = 1'b1;
`endif
            state_next   = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   reg_onehot_dec #(
      .REG_SEL_WIDTH (REG_SEL_WIDTH),
      .NUM_REGS      (NUM_REGS)
   ) u_rout_dec (
      .idx    (rout_idx),
      .en     (rout_en),
      .onehot (bus.R_out)
   );

   reg_onehot_dec #(
      .REG_SEL_WIDTH (REG_SEL_WIDTH),
      .NUM_REGS      (NUM_REGS)
   ) u_rin_dec (
      .idx    (ra),
      .en     (rin_en),
      .onehot (bus.R_in)
   );

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Randomised bench for alu_instr_sequencer: a step-list model of each instruction
// is compared against the DUT outputs on every cycle, plus directed literal checks.
module tb_alu_instr_sequencer;

   localparam int DW  = 32;
   localparam int NR  = 16;
   localparam int RSW = 4;
   localparam int OW  = 5;
`ifdef MULDIV_EN
   localparam bit MD = 1'b1;
`else
   localparam bit MD = 1'b0;
`endif

   typedef struct packed {
      logic          PCout;
      logic          Zlowout;
      logic          Zhighout;
      logic          MDRout;
      logic          MARin;
      logic          Zin;
      logic          PCin;
      logic          MDRin;
      logic          IRin;
      logic          Yin;
      logic          LOin;
      logic          HIin;
      logic          IncPC;
      logic          Read;
      logic          busy;
      logic          done;
      logic          illegal_op;
      logic [OW-1:0] alu_op;
      logic [NR-1:0] R_in;
      logic [NR-1:0] R_out;
   } outs_t;

   logic  Clock = 1'b0;
   logic  Clear_n;
   int    checks = 0;
   int    errors = 0;
   outs_t expq[$];
   outs_t dlog[0:31];
   int    nlog;

   always #5 Clock = ~Clock;

   alu_instr_sequencer_if #(.DATA_WIDTH(DW), .NUM_REGS(NR), .OPCODE_WIDTH(OW)) bus ();

   alu_instr_sequencer #(
      .DATA_WIDTH    (DW),
      .NUM_REGS      (NR),
      .REG_SEL_WIDTH (RSW),
      .OPCODE_WIDTH  (OW)
   ) dut (
      .Clock   (Clock),
      .Clear_n (Clear_n),
      .bus     (bus)
   );

   function automatic outs_t sample();
      outs_t s;
      s.PCout      = bus.PCout;
      s.Zlowout    = bus.Zlowout;
      s.Zhighout   = bus.Zhighout;
      s.MDRout     = bus.MDRout;
      s.MARin      = bus.MARin;
      s.Zin        = bus.Zin;
      s.PCin       = bus.PCin;
      s.MDRin      = bus.MDRin;
      s.IRin       = bus.IRin;
      s.Yin        = bus.Yin;
      s.LOin       = bus.LOin;
      s.HIin       = bus.HIin;
      s.IncPC      = bus.IncPC;
      s.Read       = bus.Read;
      s.busy       = bus.busy;
      s.done       = bus.done;
      s.illegal_op = bus.illegal_op;
      s.alu_op     = bus.alu_op;
      s.R_in       = bus.R_in;
      s.R_out      = bus.R_out;
      return s;
   endfunction

   function automatic void pushStep(input outs_t o);
      outs_t t;
      t      = o;
      t.busy = 1'b1;
      expq.push_back(t);
   endfunction

   // Expected output list, one entry per cycle from T0, plus a trailing idle cycle.
   function automatic void buildModel(input logic [31:0] ir, input int waits);
      outs_t o;
      int    op, ra, rb, rc;
      bit    md, bin, un;
      expq.delete();
      o = '0; o.PCout = 1; o.MARin = 1; o.IncPC = 1; o.Zin = 1; pushStep(o);
      for (int w = 0; w <= waits; w++) begin
         o = '0; o.Zlowout = 1; o.Read = 1; o.MDRin = 1; o.PCin = (w == 0); pushStep(o);
      end
      o = '0; o.MDRout = 1; o.IRin = 1; pushStep(o);
      op  = int'(ir[31:27]);
      ra  = int'(ir[26:23]);
      rb  = int'(ir[22:19]);
      rc  = int'(ir[18:15]);
      md  = MD && (op == 15 || op == 16);
      bin = (op >= 3 && op <= 11) || md;
      un  = (op == 17 || op == 18);
      if (bin) begin
         o = '0; o.R_out = NR'(1) << rb; o.Yin = 1; pushStep(o);
         o = '0; o.R_out = NR'(1) << rc; o.alu_op = OW'(op); o.Zin = 1; pushStep(o);
         if (md) begin
            o = '0; o.Zlowout = 1; o.LOin = 1; pushStep(o);
            o = '0; o.Zhighout = 1; o.HIin = 1; o.done = 1; pushStep(o);
         end else begin
            o = '0; o.Zlowout = 1; o.R_in = NR'(1) << ra; o.done = 1; pushStep(o);
         end
      end else if (un) begin
         o = '0; o.R_out = NR'(1) << rb; o.alu_op = OW'(op); o.Zin = 1; pushStep(o);
         o = '0; o.Zlowout = 1; o.R_in = NR'(1) << ra; o.done = 1; pushStep(o);
      end else begin
         o = '0; o.illegal_op = 1; pushStep(o);
      end
      o = '0;
      expq.push_back(o);
   endfunction

   task automatic checkOutput(input string name, input int c, input outs_t got, input outs_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s cycle %0d: got=%h expected=%h", name, c, got, exp);
      end
   endtask

   task automatic checkLiteral(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s: got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] ir, input int waits, input string name);
      int n;
      buildModel(ir, waits);
      n = expq.size();
      @(posedge Clock); #1;
      bus.ir        = ir;
      bus.run       = 1'b1;
      bus.mem_ready = 1'($urandom_range(0, 1));
      for (int c = 0; c < n; c++) begin
         @(posedge Clock); #1;
         bus.run = (c >= n - 2) ? 1'b0 : 1'($urandom_range(0, 1));
         if (c >= 1 && c <= waits)
            bus.mem_ready = 1'b0;
         else if (c == waits + 1)
            bus.mem_ready = 1'b1;
         else
            bus.mem_ready = 1'($urandom_range(0, 1));
         @(negedge Clock);
         dlog[c] = sample();
         checkOutput(name, c, dlog[c], expq[c]);
      end
      nlog = n;
   endtask

   function automatic int doneCycle();
      for (int c = 0; c < nlog; c++)
         if (dlog[c].done) return c;
      return -1;
   endfunction

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int          cnt_a, cnt_b, rsum;
      int          op;
      logic [31:0] rir;
      int          ops[14] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 17, 18, 0};

      Clear_n       = 1'b0;
      bus.run       = 1'b1;
      bus.mem_ready = 1'b1;
      bus.ir        = 32'h28918000;
      repeat (3) @(negedge Clock);
      checkOutput("reset", 0, sample(), '0);
      bus.run = 1'b0;
      @(negedge Clock);
      Clear_n = 1'b1;

      // and R1,R2,R3, no wait states
      applyStimulus(32'h28918000, 0, "and_nowait");
      checkLiteral("and T3 R_out", int'(dlog[3].R_out), 32'h0004);
      checkLiteral("and T3 Yin", int'(dlog[3].Yin), 1);
      checkLiteral("and T4 R_out", int'(dlog[4].R_out), 32'h0008);
      checkLiteral("and T4 alu_op", int'(dlog[4].alu_op), 5);
      checkLiteral("and T5 R_in", int'(dlog[5].R_in), 32'h0002);
      checkLiteral("and done cycle", doneCycle(), 5);

      // same instruction with three wait states
      applyStimulus(32'h28918000, 3, "and_wait3");
      cnt_a = 0;
      cnt_b = 0;
      for (int c = 0; c < nlog; c++) begin
         cnt_a += int'(dlog[c].Read && dlog[c].MDRin);
         cnt_b += int'(dlog[c].PCin);
      end
      checkLiteral("wait3 Read cycles", cnt_a, 4);
      checkLiteral("wait3 PCin cycles", cnt_b, 1);
      checkLiteral("wait3 done cycle", doneCycle(), 8);

      // neg R1,R2
      applyStimulus(32'h88900000, 0, "neg");
      checkLiteral("neg T3 R_out", int'(dlog[3].R_out), 32'h0004);
      checkLiteral("neg T3 alu_op", int'(dlog[3].alu_op), 17);
      checkLiteral("neg T3 Zin", int'(dlog[3].Zin), 1);
      checkLiteral("neg R_in", int'(dlog[4].R_in), 32'h0002);
      checkLiteral("neg done cycle", doneCycle(), 4);

      // opcode 31 is unknown
      applyStimulus(32'hF8000000, 0, "illegal");
      rsum = 0;
      for (int c = 0; c < nlog; c++)
         rsum += int'(dlog[c].R_in) + int'(dlog[c].R_out);
      checkLiteral("illegal pulse T3", int'(dlog[3].illegal_op), 1);
      checkLiteral("illegal busy after", int'(dlog[4].busy), 0);
      checkLiteral("illegal R_in/R_out", rsum, 0);

      // mul R2,R3
      applyStimulus(32'h78118000, 1, "mul");
`ifdef MULDIV_EN
      checkLiteral("mul T5 Zlowout+LOin", int'(dlog[6].Zlowout && dlog[6].LOin), 1);
      checkLiteral("mul T6 Zhighout+HIin+done",
                   int'(dlog[7].Zhighout && dlog[7].HIin && dlog[7].done), 1);
`else
      checkLiteral("mul illegal pulse", int'(dlog[4].illegal_op), 1);
      checkLiteral("mul no done", doneCycle(), -1);
`endif

      // asynchronous clear while in T4
      @(posedge Clock); #1;
      bus.ir        = 32'h28918000;
      bus.run       = 1'b1;
      bus.mem_ready = 1'b1;
      repeat (5) begin
         @(posedge Clock); #1;
         bus.run = 1'b0;
      end
      checkLiteral("pre-clear in T4 Zin", int'(bus.Zin), 1);
      #1 Clear_n = 1'b0;
      #1 checkOutput("clear_mid_T4", 4, sample(), '0);
      bus.run = 1'b1;
      @(negedge Clock);
      checkOutput("clear_held", 0, sample(), '0);
      bus.run = 1'b0;
      Clear_n = 1'b1;
      applyStimulus(32'h28918000, 0, "after_clear");

      // randomised instruction mix
      for (int t = 0; t < 60; t++) begin
         op = ops[$urandom_range(0, 13)];
         if (op == 0)
            op = int'($urandom_range(0, 31));
         rir = {op[4:0], 27'($urandom)};
         applyStimulus(rir, int'($urandom_range(0, 4)), "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
